mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-requester arbiter that shares one PicoRV32-native memory port (valid/ready/addr/wdata/wstrb/rdata) between the CPU core and a second bus master, such as a bench loader or DMA. It sits between the masters' native interfaces and the single simulation or on-chip memory model. It grants one transaction at a time in round-robin order and returns the response only to the granted master. An optional watchdog completes hung transactions with an error pattern.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width (wstrb width is DATA_W/8)
- TIMEOUT, 255, maximum wait cycles for s_ready before forced completion (used only with the watchdog)

Ports (N in {0,1}):
- clk  input  1  single clock, all logic on rising edge
- resetn  input  1  synchronous, active-low reset
- mN_valid  input  1  request from master N; held stable until mN_ready
- mN_addr  input  ADDR_W  byte address of master N
- mN_wdata  input  DATA_W  write data of master N
- mN_wstrb  input  DATA_W/8  byte strobes; zero means read
- mN_ready  output  1  one-cycle completion pulse to master N
- mN_rdata  output  DATA_W  read data, valid only while mN_ready is high
- s_valid  output  1  request to memory
- s_addr / s_wdata / s_wstrb  output  ADDR_W / DATA_W / DATA_W/8  registered copy of the granted request
- s_ready  input  1  memory accepts or completes
- s_rdata  input  DATA_W  memory read data, sampled when s_valid && s_ready
- grant_id  output  1  index of the current or last granted master
- timeout_err  output  1  sticky watchdog flag

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any mN_valid is high, choose the winner, latch its addr/wdata/wstrb into the s_* registers, set s_valid=1 and grant_id, and go to BUSY.
  - Both valid: the winner is the master indicated by rr_ptr.
  - One valid: that master wins.
  - rr_ptr is then set to the non-winner.
- BUSY:
  - s_valid stays high.
  - On s_valid && s_ready: capture s_rdata into resp_data, clear s_valid, go to RESP.
- RESP:
  - Drive m[grant_id]_ready=1 for exactly one cycle, with m[grant_id]_rdata=resp_data.
  - The other master's ready stays 0.
  - Go to IDLE.
- Writes follow the same path. resp_data is don't-care for writes but is still captured.
- The non-granted master's request is never dropped. It waits with valid high and wins the next IDLE arbitration.
- Masters must deassert valid the cycle after ready (native-bus rule). IDLE therefore never re-grants a finished request.

## Timing
- Reset (resetn=0 at a clk edge):
  - state=IDLE, rr_ptr=0, s_valid=0.
  - s_addr, s_wdata and s_wstrb are 0; mN_ready=0; mN_rdata=0; grant_id=0; timeout_err=0; watchdog count=0.
- Reset mid-transaction aborts without a response. s_valid drops at that edge.
- Minimum latency, with s_ready combinationally high:
  - Request seen in IDLE at cycle 0.
  - s_valid high in cycle 1.
  - mN_ready high in cycle 2.
  - Back-to-back throughput is one transaction per 3 cycles.
- Each additional wait cycle of s_ready adds one cycle of latency.
- s_* outputs are registered and stable for the whole BUSY state.
- mN_ready is high for exactly one cycle per granted transaction.

## Configuration
- Macro ARB_WATCHDOG_TIMEOUT_EN. When defined:
  - In BUSY, a counter increments each cycle that s_ready is 0.
  - When the count equals TIMEOUT, clear s_valid, load resp_data=32'hDEAD_BEEF and go to RESP.
  - Set timeout_err=1; it clears only on reset.
  - The counter clears on entry to BUSY.
  - If s_ready arrives in the same cycle the count reaches TIMEOUT, the normal completion wins.
- When not defined: BUSY waits indefinitely, timeout_err is tied to 0, and no counter is instantiated.

## Structure
- Package mem_arb_pkg holds:
  - the state enum (IDLE, BUSY, RESP);
  - localparam ERR_RDATA = 32'hDEAD_BEEF;
  - the requester index typedef.
- Sub-module mem_arb_watchdog holds the counter, compare and sticky flag. It is instantiated only under ARB_WATCHDOG_TIMEOUT_EN.

## Test plan
- Reset, then m0 reads 0x10 with memory returning 0x1234_5678 and zero waits. Expected: s_valid in cycle 1, m0_ready in cycle 2 with m0_rdata=0x1234_5678, m1_ready=0 throughout.
- m0 and m1 request in the same cycle after reset. Expected: m0 served first, then m1. With repeated requests the order alternates m0, m1, m0, m1 (grant_id toggles).
- m1 writes 0xCAFE_F00D to 0x20 with wstrb=4'hF and 3 wait states on s_ready. Expected: s_addr, s_wdata and s_wstrb stable for 4 cycles, then one m1_ready pulse.
- resetn asserted while in BUSY. Expected: s_valid=0 and all outputs at reset values after that edge, with no mN_ready pulse.
- With ARB_WATCHDOG_TIMEOUT_EN and TIMEOUT=8, hold s_ready=0. Expected: after 8 wait cycles s_valid drops, the requester gets ready with rdata=0xDEAD_BEEF, and timeout_err stays 1 until reset.
- With ARB_WATCHDOG_TIMEOUT_EN and TIMEOUT=8, raise s_ready exactly at wait cycle 8. Expected: the memory data is returned and timeout_err stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master memory port arbiter.
package mem_arb_pkg;

  // Arbiter sequencing: wait for a request, hold it on the memory side, answer the master
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Index of a requesting master (0 = CPU core, 1 = second bus master)
  typedef logic req_id_t;

  // Read data returned to a master whose transaction was abandoned by the watchdog
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Wait-cycle watchdog for the memory port arbiter.
// Counts cycles the memory holds off s_ready while a request is outstanding,
// raises a one-cycle expire when the count reaches TIMEOUT, and keeps a
// sticky error flag that only reset clears. Instantiated by mem_port_arbiter
// only when ARB_WATCHDOG_TIMEOUT_EN is defined.
module mem_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic busy,
  input  logic s_ready,
  output logic expire,
  output logic timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  // Expire on the wait cycle that brings the count up to TIMEOUT; a ready in that same cycle wins
  always_comb begin
    expire = busy && !s_ready && (count == CNT_W'(TIMEOUT - 1));
  end

  // Wait-cycle counter, restarted whenever a new request is granted, plus the sticky error flag
  always_ff @(posedge clk) begin
    if (!resetn) begin
      count       <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (start) begin
        count <= '0;
      end else if (busy && !s_ready && !expire) begin
        count <= count + 1'b1;
      end
      if (expire) begin
        timeout_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one PicoRV32-native memory port between two masters.
// One transaction is in flight at a time: IDLE picks a winner and registers its
// request onto the s_* port, BUSY holds it until the memory answers, RESP pulses
// the winner's ready for one cycle with the captured read data.
// Optional feature: define ARB_WATCHDOG_TIMEOUT_EN to force completion of
// transactions the memory leaves hanging for TIMEOUT wait cycles.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                resetn,

  input  logic                m0_valid,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_ready,
  output logic [DATA_W-1:0]   m0_rdata,

  input  logic                m1_valid,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_ready,
  output logic [DATA_W-1:0]   m1_rdata,

  output logic                s_valid,
  output logic [ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  input  logic                s_ready,
  input  logic [DATA_W-1:0]   s_rdata,

  output logic                grant_id,
  output logic                timeout_err
);

  arb_state_t        state;
  req_id_t           rr_ptr;
  req_id_t           winner;
  logic              any_valid;
  logic              wd_expire;
  logic              complete;
  logic [DATA_W-1:0] resp_data;

  // Pick the winner (rr_ptr breaks ties) and decide how and with what data BUSY finishes
  always_comb begin
    any_valid = m0_valid | m1_valid;
    if (m0_valid && m1_valid) begin
      winner = rr_ptr;
    end else begin
      winner = req_id_t'(m1_valid);
    end
    complete  = (state == BUSY) && (s_ready || wd_expire);
    resp_data = s_ready ? s_rdata : DATA_W'(ERR_RDATA);
  end

  // Arbitration FSM with registered memory-side request and master-side responses
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      s_valid  <= 1'b0;
      s_addr   <= '0;
      s_wdata  <= '0;
      s_wstrb  <= '0;
      grant_id <= 1'b0;
      m0_ready <= 1'b0;
      m1_ready <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            s_valid  <= 1'b1;
            s_addr   <= winner ? m1_addr  : m0_addr;
            s_wdata  <= winner ? m1_wdata : m0_wdata;
            s_wstrb  <= winner ? m1_wstrb : m0_wstrb;
            grant_id <= winner;
            rr_ptr   <= ~winner;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (complete) begin
            s_valid <= 1'b0;
            if (grant_id) begin
              m1_ready <= 1'b1;
              m1_rdata <= resp_data;
            end else begin
              m0_ready <= 1'b1;
              m0_rdata <= resp_data;
            end
            state <= RESP;
          end
        end
        RESP: begin
          m0_ready <= 1'b0;
          m1_ready <= 1'b0;
          m0_rdata <= '0;
          m1_rdata <= '0;
          state    <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef ARB_WATCHDOG_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk         (clk),
    .resetn      (resetn),
    .start       ((state == IDLE) && any_valid),
    .busy        (state == BUSY),
    .s_ready     (s_ready),
    .expire      (wd_expire),
    .timeout_err (timeout_err)
  );
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
